// File: rtl/four_bit_multiplier_ctrl.sv
// four_bit_multiplier_ctrl
//
// Sequential 4x4 unsigned shift-and-add multiplier controller. One
// partial-product step is taken per clock. Each step borrows a shared
// external four_bit_full_adder through the add_* ports. That adder lives
// outside this block and must be purely combinational.
//
// Ports
//   clk_i       in   clock, all state changes on the rising edge
//   rst_n_i     in   synchronous active-low reset
//   start_i     in   request, only honoured in IDLE
//   a_i[3:0]    in   multiplicand, captured with start_i
//   b_i[3:0]    in   multiplier, captured with start_i
//   busy_o      out  high in every state other than IDLE
//   done_o      out  one-cycle completion pulse (the DONE state)
//   product_o   out  last completed product, held until the next completion
//   add_a_o     out  adder operand A (running upper partial product)
//   add_b_o     out  adder operand B (multiplicand or zero)
//   add_cin_o   out  adder carry-in, tied low
//   add_s_i     in   adder sum
//   add_cout_i  in   adder carry-out
module four_bit_multiplier_ctrl (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] product_o,
  output logic [3:0] add_a_o,
  output logic [3:0] add_b_o,
  output logic       add_cin_o,
  input  logic [3:0] add_s_i,
  input  logic       add_cout_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] acc;
  logic [3:0] mq;
  logic [3:0] mcand;
  logic [1:0] cnt;
  logic       busy;
  logic       done;
  logic [7:0] product;

  // The adder is driven only from registers, never from start_i/a_i/b_i.
  // Outside CALC, both operands are forced to zero so that the shared adder
  // sees a quiet input.
  always_comb begin
    add_a_o   = 4'h0;
    add_b_o   = 4'h0;
    add_cin_o = 1'b0;
    if (state == CALC) begin
      add_a_o = acc;
      add_b_o = mq[0] ? mcand : 4'h0;
    end
  end

  // Each step shifts {cout, sum, mq} right by one. The carry-out is kept
  // in the accumulator MSB, so the 8-bit result can never overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      acc     <= 4'h0;
      mq      <= 4'h0;
      mcand   <= 4'h0;
      cnt     <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start_i) begin
            mcand <= a_i;
            mq    <= b_i;
            acc   <= 4'h0;
            cnt   <= 2'd0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= {add_cout_i, add_s_i[3:1]};
          mq  <= {add_s_i[0], mq[3:1]};
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            // Capture the post-shift {acc, mq} directly from the adder
            // result. This makes product_o line up with done_o.
            product <= {add_cout_i, add_s_i, mq[3:1]};
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy;
  assign done_o    = done;
  assign product_o = product;

endmodule

// File: tb/tb_four_bit_multiplier_ctrl.sv
// Testbench for four_bit_multiplier_ctrl. It provides a behavioural
// four_bit_full_adder on the add_* ports and checks the results against
// hand-computed products and a step model of the shift-and-add algorithm.
module tb_four_bit_multiplier_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_s;
  logic       add_cout;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cin_bad = 0;

  four_bit_multiplier_ctrl dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .product_o  (product),
    .add_a_o    (add_a),
    .add_b_o    (add_b),
    .add_cin_o  (add_cin),
    .add_s_i    (add_s),
    .add_cout_i (add_cout)
  );

  // Behavioural adder
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pre-edge values sampled at each rising edge: each done pulse counted once
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (add_cin !== 1'b0) cin_bad <= cin_bad + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Full operation starting from IDLE, with the bench sitting at a negedge.
  // With detailed=1, the task also checks the adder drive on every step
  // against a step model.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb,
                        input logic [7:0] exp, input bit detailed);
    logic [3:0] macc;
    logic [3:0] mmq;
    logic [3:0] opb;
    logic [4:0] sum;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb;
    @(negedge clk);                       // E0 has passed, first CALC cycle
    start = 1'b0; a = ~ta; b = ~tb;       // operands must not be re-sampled
    macc = 4'h0;
    mmq  = tb;
    for (int i = 0; i < 4; i++) begin
      if (detailed) begin
        opb = mmq[0] ? ta : 4'h0;
        chk("calc_busy", 8'(busy), 8'd1);
        chk("calc_done", 8'(done), 8'd0);
        chk("calc_add_a", 8'(add_a), 8'(macc));
        chk("calc_add_b", 8'(add_b), 8'(opb));
        sum  = {1'b0, macc} + {1'b0, opb};
        macc = sum[4:1];
        mmq  = {sum[0], mmq[3:1]};
      end
      @(negedge clk);
    end
    // DONE cycle (between E4 and E5)
    chk("done_pulse", 8'(done), 8'd1);
    chk("done_product", product, exp);
    if (detailed) begin
      chk("done_busy", 8'(busy), 8'd1);
      chk("done_add_a", 8'(add_a), 8'd0);
      chk("done_add_b", 8'(add_b), 8'd0);
    end
    @(negedge clk);                       // back in IDLE after E5
    if (detailed) begin
      chk("idle_done", 8'(done), 8'd0);
      chk("idle_busy", 8'(busy), 8'd0);
      chk("idle_product_hold", product, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int d0;
    int n;
    int g;
    vecs[0] = '{a: 4'd3,  b: 4'd5,  p: 8'h0F};
    vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
    vecs[2] = '{a: 4'd0,  b: 4'd15, p: 8'h00};
    vecs[3] = '{a: 4'd15, b: 4'd1,  p: 8'h0F};
    vecs[4] = '{a: 4'd8,  b: 4'd8,  p: 8'h40};
    vecs[5] = '{a: 4'd7,  b: 4'd9,  p: 8'h3F};
    vecs[6] = '{a: 4'd1,  b: 4'd10, p: 8'h0A};

    rst_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_product", product, 8'h00);
    chk("rst_add_a", 8'(add_a), 8'd0);
    chk("rst_add_b", 8'(add_b), 8'd0);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b1);

    // Start while busy: 7*9, then 2*2 requested during CALC and DONE
    @(negedge clk);
    start = 1'b1; a = 4'd7; b = 4'd9;
    @(negedge clk);                       // after E0
    start = 1'b0;
    d0 = done_cnt;
    @(negedge clk);                       // after E1
    start = 1'b1; a = 4'd2; b = 4'd2;
    repeat (3) @(negedge clk);            // after E4: DONE cycle
    chk("busy_start_done", 8'(done), 8'd1);
    chk("busy_start_product", product, 8'h3F);
    @(negedge clk);                       // after E5: start at E5 was ignored
    start = 1'b0;
    chk("busy_start_idle", 8'(busy), 8'd0);
    repeat (8) @(negedge clk);
    chk("busy_start_pulses", 8'(done_cnt - d0), 8'd1);
    chk("busy_start_hold", product, 8'h3F);
    chk("busy_start_busy", 8'(busy), 8'd0);

    // Back-to-back with start held high: 6*7 then 4*4
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; a = 4'd6; b = 4'd7;
    @(negedge clk);                       // after E0
    a = 4'd4; b = 4'd4;
    chk("b2b_busy", 8'(busy), 8'd1);
    for (n = 0; n < 10 && done !== 1'b1; n++) @(negedge clk);
    chk("b2b_latency", 8'(n), 8'd4);
    chk("b2b_first", product, 8'h2A);
    for (g = 0; g < 12; g++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (g == 0) chk("b2b_gap_idle", 8'(busy), 8'd0);
      chk("b2b_hold", product, 8'h2A);
    end
    chk("b2b_period", 8'(g + 1), 8'd6);
    chk("b2b_second", product, 8'h10);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_pulses", 8'(done_cnt - d0), 8'd2);

    // Reset after E2 of 13*11
    @(negedge clk);
    start = 1'b1; a = 4'd13; b = 4'd11;
    @(negedge clk);                       // after E0
    start = 1'b0;
    repeat (2) @(negedge clk);            // after E2
    rst_n = 1'b0;
    d0 = done_cnt;
    @(negedge clk);                       // after reset edge E3
    rst_n = 1'b1;
    chk("midrst_busy", 8'(busy), 8'd0);
    chk("midrst_done", 8'(done), 8'd0);
    chk("midrst_product", product, 8'h00);
    chk("midrst_add_a", 8'(add_a), 8'd0);
    chk("midrst_add_b", 8'(add_b), 8'd0);
    repeat (8) @(negedge clk);
    chk("midrst_no_done", 8'(done_cnt - d0), 8'd0);
    chk("midrst_idle", 8'(busy), 8'd0);
    run_op(4'd2, 4'd3, 8'h06, 1'b1);

    // Exhaustive sweep
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        run_op(4'(ia), 4'(ib), 8'(ia * ib), 1'b0);
    chk("cin_never_high", 8'(cin_bad), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
